// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MIPS memory stage. Takes the Execute outputs (ALU result, zero flag,
// branch target, store data) plus pipeline control, resolves branches,
// performs loads/stores over a req/ready data-memory port and hands one
// registered writeback record per instruction to the WB stage. Execute is
// stalled while a memory access is outstanding.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid              Execute presents an instruction this cycle
//   ex_result             ALU result (memory address for loads/stores)
//   ex_zero               ALU zero flag
//   ex_add_result         branch target
//   ex_store_data         rt value for stores
//   ex_write_reg          destination register
//   ex_mem_read/ex_mem_write/ex_branch/ex_reg_write/ex_mem_to_reg  control
//   ex_stall              Execute must hold its outputs stable
//   pc_src, branch_target take-branch pulse and its target
//   dmem_req/dmem_we/dmem_addr/dmem_wdata   data-memory request
//   dmem_ready/dmem_rdata                   data-memory response
//   wb_valid, wb_reg_write, wb_write_reg, wb_data,
//   wb_misaligned, wb_bus_error             writeback record
//   dbg_state             current FSM state (0 = IDLE, 1 = ACCESS)
//
// Handshake: a memory transfer completes on every rising edge where
// dmem_req and dmem_ready are both 1. Once raised, dmem_req, dmem_we,
// dmem_addr and dmem_wdata stay constant until that edge (or until the
// wait limit aborts the request); dmem_rdata is sampled only on the
// completing edge.
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_add_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_write_reg,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_branch,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    output logic              ex_stall,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_write_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_misaligned,
    output logic              wb_bus_error,
    output logic              dbg_state
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Control of the instruction parked in ACCESS. The address doubles as
    // the held ALU result, so it is not stored twice.
    logic             hold_write;
    logic             hold_reg_write;
    logic             hold_mem_to_reg;
    logic [REG_W-1:0] hold_write_reg;

    logic             is_mem;
    logic             misaligned;
    logic [CNT_W-1:0] cnt_next;
    logic             timeout;

    assign is_mem     = ex_mem_read | ex_mem_write;
    assign misaligned = (ex_result[1:0] != 2'b00);
    assign cnt_next   = wait_cnt + 1'b1;
    // The cycle that would bring the count to the limit is the last one
    // the request is allowed to stay unanswered.
    assign timeout    = (cnt_next == WAIT_LIMIT);

    assign ex_stall  = (state == ACCESS);
    assign dbg_state = (state == ACCESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            hold_write      <= 1'b0;
            hold_reg_write  <= 1'b0;
            hold_mem_to_reg <= 1'b0;
            hold_write_reg  <= '0;
            pc_src          <= 1'b0;
            branch_target   <= '0;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            wb_valid        <= 1'b0;
            wb_reg_write    <= 1'b0;
            wb_write_reg    <= '0;
            wb_data         <= '0;
            wb_misaligned   <= 1'b0;
            wb_bus_error    <= 1'b0;
        end else begin
            // Both pulses default low; only a capture or completion raises them.
            wb_valid <= 1'b0;
            pc_src   <= 1'b0;

            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        pc_src        <= ex_branch & ex_zero;
                        branch_target <= ex_add_result;
                        if (!is_mem) begin
                            wb_valid      <= 1'b1;
                            wb_reg_write  <= ex_reg_write;
                            wb_write_reg  <= ex_write_reg;
                            wb_data       <= ex_result;
                            wb_misaligned <= 1'b0;
                            wb_bus_error  <= 1'b0;
                        end else if (misaligned) begin
                            // Never reaches the bus; retire immediately as an exception.
                            wb_valid      <= 1'b1;
                            wb_reg_write  <= 1'b0;
                            wb_write_reg  <= ex_write_reg;
                            wb_data       <= ex_result;
                            wb_misaligned <= 1'b1;
                            wb_bus_error  <= 1'b0;
                        end else begin
                            state           <= ACCESS;
                            wait_cnt        <= '0;
                            dmem_req        <= 1'b1;
                            // Read+write together is treated as a write.
                            dmem_we         <= ex_mem_write;
                            dmem_addr       <= ex_result;
                            dmem_wdata      <= ex_store_data;
                            hold_write      <= ex_mem_write;
                            hold_reg_write  <= ex_reg_write;
                            hold_mem_to_reg <= ex_mem_to_reg;
                            hold_write_reg  <= ex_write_reg;
                        end
                    end
                end

                ACCESS: begin
                    // ready is tested first so it wins over a same-edge timeout.
                    if (dmem_ready) begin
                        state         <= IDLE;
                        wait_cnt      <= '0;
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_reg_write  <= hold_reg_write & ~hold_write;
                        wb_write_reg  <= hold_write_reg;
                        wb_data       <= hold_mem_to_reg ? dmem_rdata : dmem_addr;
                        wb_misaligned <= 1'b0;
                        wb_bus_error  <= 1'b0;
                    end else if (timeout) begin
                        state         <= IDLE;
                        wait_cnt      <= '0;
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_reg_write  <= 1'b0;
                        wb_write_reg  <= hold_write_reg;
                        wb_data       <= dmem_addr;
                        wb_misaligned <= 1'b0;
                        wb_bus_error  <= 1'b1;
                    end else begin
                        wait_cnt <= cnt_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int MAX_WAIT = 4;

    logic              clk;
    logic              rst_n;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_result;
    logic              ex_zero;
    logic [DATA_W-1:0] ex_add_result;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_W-1:0]  ex_write_reg;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_branch;
    logic              ex_reg_write;
    logic              ex_mem_to_reg;
    logic              ex_stall;
    logic              pc_src;
    logic [DATA_W-1:0] branch_target;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;
    logic              wb_valid;
    logic              wb_reg_write;
    logic [REG_W-1:0]  wb_write_reg;
    logic [DATA_W-1:0] wb_data;
    logic              wb_misaligned;
    logic              wb_bus_error;
    logic              dbg_state;

    int checks   = 0;
    int failures = 0;
    int req_cycles;

    mem_stage #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_result    (ex_result),
        .ex_zero      (ex_zero),
        .ex_add_result(ex_add_result),
        .ex_store_data(ex_store_data),
        .ex_write_reg (ex_write_reg),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_branch    (ex_branch),
        .ex_reg_write (ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg),
        .ex_stall     (ex_stall),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_write_reg (wb_write_reg),
        .wb_data      (wb_data),
        .wb_misaligned(wb_misaligned),
        .wb_bus_error (wb_bus_error),
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_ex();
        ex_valid      = 1'b0;
        ex_result     = '0;
        ex_zero       = 1'b0;
        ex_add_result = '0;
        ex_store_data = '0;
        ex_write_reg  = '0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_branch     = 1'b0;
        ex_reg_write  = 1'b0;
        ex_mem_to_reg = 1'b0;
    endtask

    // Driver: present a single instruction on the Execute outputs.
    task automatic drive_ex(input logic [31:0] result, input logic [4:0] wreg,
                            input logic rd, input logic wr, input logic rw,
                            input logic m2r, input logic [31:0] sdata);
        clear_ex();
        ex_valid      = 1'b1;
        ex_result     = result;
        ex_write_reg  = wreg;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_reg_write  = rw;
        ex_mem_to_reg = m2r;
        ex_store_data = sdata;
    endtask

    initial begin
        clear_ex();
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_ex_stall", 32'(ex_stall), 32'd0);
        check("rst_pc_src",   32'(pc_src),   32'd0);
        check("rst_wb_data",  wb_data,       32'd0);
        check("rst_state",    32'(dbg_state), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Idle with no instruction
        check("idle_wb_valid", 32'(wb_valid), 32'd0);

        // ALU op: result 0x1234 -> r5, one-cycle latency
        drive_ex(32'h1234, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("alu_wb_valid", 32'(wb_valid),     32'd1);
        check("alu_wb_data",  wb_data,           32'h1234);
        check("alu_wb_reg",   32'(wb_write_reg), 32'd5);
        check("alu_wb_rw",    32'(wb_reg_write), 32'd1);
        check("alu_no_req",   32'(dmem_req),     32'd0);
        clear_ex();
        tick();
        check("alu_pulse_end", 32'(wb_valid), 32'd0);

        // Load 0x100 -> r7, ready in the third request cycle
        drive_ex(32'h100, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        tick();
        clear_ex();
        check("ld_req_c1",   32'(dmem_req), 32'd1);
        check("ld_stall_c1", 32'(ex_stall), 32'd1);
        check("ld_addr",     dmem_addr,     32'h100);
        check("ld_we",       32'(dmem_we),  32'd0);
        check("ld_wb_c1",    32'(wb_valid), 32'd0);
        tick();
        check("ld_req_c2", 32'(dmem_req), 32'd1);
        tick();
        check("ld_req_c3",  32'(dmem_req), 32'd1);
        check("ld_addr_c3", dmem_addr,     32'h100);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFEBABE;
        tick();
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        check("ld_req_done",  32'(dmem_req),     32'd0);
        check("ld_stall_done",32'(ex_stall),     32'd0);
        check("ld_wb_valid",  32'(wb_valid),     32'd1);
        check("ld_wb_data",   wb_data,           32'hCAFEBABE);
        check("ld_wb_rw",     32'(wb_reg_write), 32'd1);
        check("ld_wb_reg",    32'(wb_write_reg), 32'd7);
        tick();
        check("ld_pulse_end", 32'(wb_valid), 32'd0);

        // Store 0x104 data 0xDEAD, ready immediately. While in ACCESS an ALU
        // op (0x55 -> r3) is held on the inputs; it must wait one bubble.
        drive_ex(32'h104, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD);
        tick();
        check("st_req",   32'(dmem_req), 32'd1);
        check("st_we",    32'(dmem_we),  32'd1);
        check("st_addr",  dmem_addr,     32'h104);
        check("st_wdata", dmem_wdata,    32'hDEAD);
        drive_ex(32'h55, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        check("st_req_done", 32'(dmem_req),     32'd0);
        check("st_wb_valid", 32'(wb_valid),     32'd1);
        check("st_wb_rw",    32'(wb_reg_write), 32'd0);
        check("st_wb_reg",   32'(wb_write_reg), 32'd9);
        tick();
        clear_ex();
        check("held_wb_valid", 32'(wb_valid),     32'd1);
        check("held_wb_data",  wb_data,           32'h55);
        check("held_wb_reg",   32'(wb_write_reg), 32'd3);
        check("held_wb_rw",    32'(wb_reg_write), 32'd1);
        tick();
        check("held_pulse_end", 32'(wb_valid), 32'd0);

        // Read and write both set: acts as a store, no register write
        drive_ex(32'h108, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 32'h77);
        tick();
        clear_ex();
        check("rw_we", 32'(dmem_we), 32'd1);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1111;
        tick();
        dmem_ready = 1'b0;
        check("rw_wb_valid", 32'(wb_valid),     32'd1);
        check("rw_wb_rw",    32'(wb_reg_write), 32'd0);

        // Branch taken: zero=1, target 0x40
        clear_ex();
        ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1; ex_add_result = 32'h40;
        tick();
        clear_ex();
        check("br_pc_src", 32'(pc_src),  32'd1);
        check("br_target", branch_target, 32'h40);
        check("br_wb",     32'(wb_valid), 32'd1);
        tick();
        check("br_pulse_end", 32'(pc_src), 32'd0);
        // Branch not taken
        ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b0; ex_add_result = 32'h80;
        tick();
        clear_ex();
        check("br_nt_pc_src", 32'(pc_src), 32'd0);

        // Misaligned load 0x102
        drive_ex(32'h102, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        tick();
        clear_ex();
        check("mis_req",     32'(dmem_req),      32'd0);
        check("mis_stall",   32'(ex_stall),      32'd0);
        check("mis_wb",      32'(wb_valid),      32'd1);
        check("mis_flag",    32'(wb_misaligned), 32'd1);
        check("mis_wb_rw",   32'(wb_reg_write),  32'd0);
        tick();
        check("mis_pulse_end", 32'(wb_valid), 32'd0);

        // Load that is never answered: bus error after MAX_WAIT request cycles
        drive_ex(32'h200, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        tick();
        clear_ex();
        req_cycles = 0;
        while (dmem_req === 1'b1 && req_cycles < 20) begin
            req_cycles++;
            tick();
        end
        check("to_req_cycles", 32'(req_cycles),    32'(MAX_WAIT));
        check("to_wb",         32'(wb_valid),      32'd1);
        check("to_bus_error",  32'(wb_bus_error),  32'd1);
        check("to_wb_rw",      32'(wb_reg_write),  32'd0);
        check("to_misaligned", 32'(wb_misaligned), 32'd0);
        check("to_stall",      32'(ex_stall),      32'd0);

        // Ready on the same edge as the timeout: normal completion wins
        drive_ex(32'h300, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        tick();
        clear_ex();
        repeat (MAX_WAIT - 1) tick();
        check("race_req", 32'(dmem_req), 32'd1);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        tick();
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        check("race_wb",        32'(wb_valid),     32'd1);
        check("race_bus_error", 32'(wb_bus_error), 32'd0);
        check("race_wb_data",   wb_data,           32'h0BADF00D);
        check("race_wb_rw",     32'(wb_reg_write), 32'd1);

        // Asynchronous reset in the middle of an access
        drive_ex(32'h400, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        tick();
        clear_ex();
        check("ar_req_before", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_req_async",   32'(dmem_req),  32'd0);
        check("ar_stall_async", 32'(ex_stall),  32'd0);
        check("ar_state_async", 32'(dbg_state), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_no_wb", 32'(wb_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
